dummy_iter: RTL and testbench

DUMMY_ITER -- requirements
Module: dummy_iter

---
 rtl/dummy_pkg.sv | 26 ++
 rtl/dummy_iter_cnt.sv | 37 +++
 rtl/dummy_iter.sv | 99 +++++++++
 tb/tb_dummy_iter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dummy_pkg.sv
// Shared types for the dummy execution datapath.
// Holds the operation mode and result-select types used by the control unit,
// and the result-half select used by the iterative multiplier (dummy_iter).
package dummy_pkg;

  // Operation class requested by the control unit.
  typedef enum logic [1:0] {
    MODE_ALU  = 2'd0,
    MODE_MUL  = 2'd1,
    MODE_MULH = 2'd2,
    MODE_NOP  = 2'd3
  } dummy_mode_t;

  // Which unit drives the writeback result.
  typedef enum logic {
    RES_ALU  = 1'b0,
    RES_ITER = 1'b1
  } dummy_res_sel_t;

  // Which half of the 2*WIDTH-bit product is returned.
  typedef enum logic {
    ITER_LO = 1'b0,
    ITER_HI = 1'b1
  } iter_half_t;

endpackage

// File: rtl/dummy_iter_cnt.sv
// Saturating up-counter for the iterative multiplier.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear (wins over en_i)
//   en_i   - count enable; ignored once the terminal value is reached
//   tc_o   - high while the count equals TERM
module dummy_iter_cnt #(
  parameter int CNT_W = 6,
  parameter int TERM  = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == TERM_V);
  assign tc_o = w_tc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dummy_iter.sv
// Iterative radix-2 shift-add unsigned multiplier, sequenced by the control
// unit's strobes (no internal FSM).
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   flush_i       - abort in-flight operation, clears datapath
//   reg_en_i      - load operands and start a new operation
//   cnt_en_i      - perform one shift-add step
//   cnt_clr_i     - retire the operation (result retained)
//   op_a_i/op_b_i - multiplicand / multiplier
//   hi_i          - 1 selects upper WIDTH bits of the product
//   tc_o          - result is final
//   busy_o        - an operation is loaded and not yet cleared
//   res_o         - selected half of the product
module dummy_iter
  import dummy_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             reg_en_i,
  input  logic             cnt_en_i,
  input  logic             cnt_clr_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             hi_i,
  output logic             tc_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  iter_half_t         r_hi;
  logic               r_busy;

  logic w_cnt_tc;
  logic w_tc;
  logic w_step;
  logic w_cnt_clr;

  // Early exit: once the multiplier has no set bits left, the product is final.
  assign w_tc = r_busy & (w_cnt_tc | (r_b == '0));

  // A step only happens when no higher-priority strobe is active.
  assign w_step    = cnt_en_i & r_busy & ~w_tc & ~flush_i & ~cnt_clr_i & ~reg_en_i;
  assign w_cnt_clr = flush_i | cnt_clr_i | reg_en_i;

  dummy_iter_cnt #(
    .CNT_W (CNT_W),
    .TERM  (WIDTH)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_cnt_clr),
    .en_i  (w_step),
    .tc_o  (w_cnt_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_hi   <= ITER_LO;
      r_busy <= 1'b0;
    end else if (flush_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_busy <= 1'b0;
    end else if (cnt_clr_i) begin
      // Accumulator is kept so the result stays readable after retirement.
      r_busy <= 1'b0;
    end else if (reg_en_i) begin
      r_a    <= {{WIDTH{1'b0}}, op_a_i};
      r_b    <= op_b_i;
      r_acc  <= '0;
      r_hi   <= iter_half_t'(hi_i);
      r_busy <= 1'b1;
    end else if (w_step) begin
      // Full 2*WIDTH add: the final product always fits, so no carry is lost.
      if (r_b[0]) begin
        r_acc <= r_acc + r_a;
      end
      r_a <= r_a << 1;
      r_b <= r_b >> 1;
    end
  end

  assign tc_o   = w_tc;
  assign busy_o = r_busy;
  assign res_o  = (r_hi == ITER_HI) ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];

endmodule

// File: tb/tb_dummy_iter.sv
module tb_dummy_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         reg_en;
  logic         cnt_en;
  logic         cnt_clr;
  logic         hi;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         tc;
  logic         busy;
  logic [W-1:0] res;

  dummy_iter #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .reg_en_i  (reg_en),
    .cnt_en_i  (cnt_en),
    .cnt_clr_i (cnt_clr),
    .op_a_i    (a),
    .op_b_i    (b),
    .hi_i      (hi),
    .tc_o      (tc),
    .busy_o    (busy),
    .res_o     (res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           ld;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errs   = 0;
  int   checks = 0;
  logic prev_tc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising tc_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && tc && !prev_tc) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_tc: got tc=1 with no operation expected (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_result", {32'h0, res}, {32'h0, e.res});
        chk("sb_latency", 64'(cyc - e.ld), 64'(e.lat));
      end
    end
    prev_tc <= tc;
  end

  // Retire the previous op, then load; lat counts cycles from the load cycle.
  task automatic load(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ih,
                      input int lat, input logic [W-1:0] er, input logic push);
    @(negedge clk);
    cnt_clr = 1'b1;
    reg_en  = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b0;
    reg_en  = 1'b1;
    cnt_en  = 1'b1;
    a       = ia;
    b       = ib;
    hi      = ih;
    if (push) sb.push_back('{er, lat, cyc});
    @(negedge clk);
    reg_en  = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; reg_en = 1'b0; cnt_en = 1'b0; cnt_clr = 1'b0;
    hi = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_tc",   {63'h0, tc},   64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_res",  {32'h0, res},  64'h0);
    rst = 1'b0;

    // 3*5, lo
    load(32'd3, 32'd5, 1'b0, 4, 32'd15, 1'b1);
    wait_done(50);
    chk("mul3x5_cnt",  64'(dut.u_cnt.r_cnt), 64'd3);
    chk("mul3x5_busy", {63'h0, busy}, 64'h1);

    // multiplier zero: immediate terminal count
    load(32'h1234, 32'd0, 1'b0, 1, 32'd0, 1'b1);
    wait_done(50);

    // all-ones squared, both halves
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33, 32'hFFFF_FFFE, 1'b1);
    wait_done(60);
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 32'h0000_0001, 1'b1);
    wait_done(60);

    // 7*9, hold past tc, then clear
    load(32'd7, 32'd9, 1'b0, 5, 32'd63, 1'b1);
    wait_done(50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_res", {32'h0, res}, 64'd63);
      chk("hold_tc",  {63'h0, tc},  64'h1);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_busy", {63'h0, busy}, 64'h0);
    chk("clr_tc",   {63'h0, tc},   64'h0);
    chk("clr_res",  {32'h0, res},  64'd63);

    // flush mid-operation
    load(32'd5, 32'h8000_0000, 1'b0, 0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_res",  {32'h0, res},  64'h0);
    chk("flush_busy", {63'h0, busy}, 64'h0);
    chk("flush_tc",   {63'h0, tc},   64'h0);
    repeat (30) @(negedge clk);
    chk("flush_no_tc", {63'h0, tc}, 64'h0);
    load(32'd2, 32'd3, 1'b0, 3, 32'd6, 1'b1);
    wait_done(50);

    // asynchronous reset mid-operation
    load(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tc",   {63'h0, tc},   64'h0);
    chk("async_rst_busy", {63'h0, busy}, 64'h0);
    chk("async_rst_res",  {32'h0, res},  64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_tc",   {63'h0, tc},   64'h0);
    chk("post_rst_busy", {63'h0, busy}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
